// File: rtl/debounce_bank.sv
// Multi-channel push-button synchroniser and integrating debouncer sharing one sample-tick divider.
// Define DEBOUNCE_AUTOREPEAT_EN to build per-channel hold counters that drive o_repeat.
module debounce_bank #(
   parameter int N_BTN        = 4,
   parameter int TICK_DIV     = 250000,
   parameter int STABLE_TICKS = 4,
   parameter int ACTIVE_LOW   = 0,
   parameter int REPEAT_DELAY = 200,
   parameter int REPEAT_RATE  = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_level,
   output logic [N_BTN-1:0] o_press,
   output logic [N_BTN-1:0] o_release,
   output logic [N_BTN-1:0] o_repeat,
   output logic             o_tick
);
   localparam int DIV_W = $clog2(TICK_DIV);
   localparam int INT_W = $clog2(STABLE_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [INT_W-1:0] INT_LAST = INT_W'(STABLE_TICKS - 1);

   if (N_BTN < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
      $error("debounce_bank: illegal parameter set");
   end

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   logic [N_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [N_BTN-1:0] level_q, level_d;
   logic [N_BTN-1:0] press_q, press_d;
   logic [N_BTN-1:0] release_q, release_d;
   logic [INT_W-1:0] int_q [N_BTN];
   logic [INT_W-1:0] int_d [N_BTN];

   // Polarity is folded in ahead of the synchroniser so everything downstream sees 1 = pressed.
   always_comb begin
      tick    = (div_q == DIV_LAST);
      div_d   = tick ? '0 : div_q + DIV_W'(1);
      sync1_d = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;
      sync2_d = sync1_q;
   end

   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      int_d     = int_q;
      for (int i = 0; i < N_BTN; i++) begin
         if (tick) begin
            if (sync2_q[i] == level_q[i]) begin
               int_d[i] = '0;
            end else if (int_q[i] == INT_LAST) begin
               int_d[i]     = '0;
               level_d[i]   = sync2_q[i];
               press_d[i]   = sync2_q[i];
               release_d[i] = ~sync2_q[i];
            end else begin
               int_d[i] = int_q[i] + INT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < N_BTN; i++) int_q[i] <= '0;
      end else begin
         div_q     <= div_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < N_BTN; i++) int_q[i] <= int_d[i];
      end
   end

   assign o_level   = level_q;
   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_tick    = tick;

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int HOLD_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
   localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
   localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_DELAY + REPEAT_RATE);

   logic [HOLD_W-1:0] hold_q [N_BTN];
   logic [HOLD_W-1:0] hold_d [N_BTN];
   logic [HOLD_W-1:0] hold_inc;
   logic [N_BTN-1:0]  repeat_q, repeat_d;

   // After the first repeat the counter folds back to REPEAT_DELAY, so it never exceeds DELAY+RATE.
   always_comb begin
      repeat_d = '0;
      hold_inc = '0;
      hold_d   = hold_q;
      for (int i = 0; i < N_BTN; i++) begin
         if (!level_q[i] || release_d[i]) begin
            hold_d[i] = '0;
         end else if (tick) begin
            hold_inc = hold_q[i] + HOLD_W'(1);
            if (hold_inc == HOLD_NEXT) begin
               repeat_d[i] = 1'b1;
               hold_d[i]   = HOLD_FIRST;
            end else begin
               repeat_d[i] = (hold_inc == HOLD_FIRST);
               hold_d[i]   = hold_inc;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         repeat_q <= '0;
         for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
      end else begin
         repeat_q <= repeat_d;
         for (int i = 0; i < N_BTN; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign o_repeat = repeat_q;
`else
   assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: an active-high and an active-low instance share one input bus,
// and a tick-level behavioural model predicts levels and strobe events for both.
module tb_debounce_bank;
   localparam int NB = 4;
   localparam int TD = 4;
   localparam int ST = 3;
   localparam int RD = 5;
   localparam int RR = 2;

   logic          clk, rst;
   logic [NB-1:0] i_btn;
   logic [NB-1:0] o_level_a, o_press_a, o_release_a, o_repeat_a;
   logic [NB-1:0] o_level_b, o_press_b, o_release_b, o_repeat_b;
   logic          o_tick_a, o_tick_b;

   debounce_bank #(.N_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(0),
                   .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_a (
      .clk(clk), .rst(rst), .i_btn(i_btn), .o_level(o_level_a), .o_press(o_press_a),
      .o_release(o_release_a), .o_repeat(o_repeat_a), .o_tick(o_tick_a));

   debounce_bank #(.N_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1),
                   .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_b (
      .clk(clk), .rst(rst), .i_btn(i_btn), .o_level(o_level_b), .o_press(o_press_b),
      .o_release(o_release_b), .o_repeat(o_repeat_b), .o_tick(o_tick_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      int            edge_n;
      logic [NB-1:0] pr_a, rl_a, rp_a, pr_b, rl_b, rp_b;
   } ev_t;

   ev_t           exp_q[$];
   int            edge_n;
   logic [NB-1:0] pipe_a[$], pipe_b[$];
   logic [NB-1:0] lvl_m [2];
   int            run_m [2][NB];
   int            held_m [2][NB];
   logic          tick_m;
   logic [NB-1:0] sa, sb, pa, ra, qa, pb, rb, qb;
   ev_t           ev;

   // A level flips once ST consecutive tick samples disagree with it; repeats count held ticks since press.
   task automatic model_dut(input int d, input logic [NB-1:0] s, input bit tk,
                            output logic [NB-1:0] pr, output logic [NB-1:0] rl, output logic [NB-1:0] rp);
      pr = '0; rl = '0; rp = '0;
      if (tk) begin
         for (int i = 0; i < NB; i++) begin
            if (s[i] != lvl_m[d][i]) run_m[d][i]++;
            else run_m[d][i] = 0;
            if (run_m[d][i] >= ST) begin
               lvl_m[d][i] = s[i];
               run_m[d][i] = 0;
               held_m[d][i] = 0;
               if (s[i]) pr[i] = 1'b1;
               else rl[i] = 1'b1;
            end else if (lvl_m[d][i]) begin
               held_m[d][i]++;
               if (held_m[d][i] == RD || (held_m[d][i] > RD && (held_m[d][i] - RD) % RR == 0)) rp[i] = 1'b1;
            end
         end
      end
`ifndef DEBOUNCE_AUTOREPEAT_EN
      rp = '0;
`endif
   endtask

   always @(posedge clk) begin
      if (rst) begin
         edge_n = 0;
         tick_m = 1'b0;
         pipe_a.delete();
         pipe_b.delete();
         pipe_a.push_back('0); pipe_a.push_back('0);
         pipe_b.push_back('0); pipe_b.push_back('0);
         for (int d = 0; d < 2; d++) begin
            lvl_m[d] = '0;
            for (int i = 0; i < NB; i++) begin
               run_m[d][i] = 0;
               held_m[d][i] = 0;
            end
         end
      end else begin
         edge_n++;
         sa = pipe_a.pop_front();
         pipe_a.push_back(i_btn);
         sb = pipe_b.pop_front();
         pipe_b.push_back(~i_btn);
         model_dut(0, sa, (edge_n % TD) == 0, pa, ra, qa);
         model_dut(1, sb, (edge_n % TD) == 0, pb, rb, qb);
         tick_m = ((edge_n % TD) == TD - 1);
         if (|{pa, ra, qa, pb, rb, qb}) begin
            ev.edge_n = edge_n;
            ev.pr_a = pa; ev.rl_a = ra; ev.rp_a = qa;
            ev.pr_b = pb; ev.rl_b = rb; ev.rp_b = qb;
            exp_q.push_back(ev);
         end
      end
   end

   // ---------------- monitor ----------------
   logic [23:0] got_s, want_s;
   ev_t         mev;

   always @(negedge clk) begin
      chk("level_a", 32'(o_level_a), 32'(lvl_m[0]));
      chk("level_b", 32'(o_level_b), 32'(lvl_m[1]));
      chk("tick", 32'({o_tick_a, o_tick_b}), 32'({tick_m, tick_m}));
      got_s = {o_press_a, o_release_a, o_repeat_a, o_press_b, o_release_b, o_repeat_b};
      if (got_s != '0 || (exp_q.size() > 0 && exp_q[0].edge_n <= edge_n)) begin
         if (exp_q.size() == 0) begin
            chk("strobe_unexpected", 32'(got_s), 32'd0);
         end else begin
            mev = exp_q.pop_front();
            want_s = {mev.pr_a, mev.rl_a, mev.rp_a, mev.pr_b, mev.rl_b, mev.rp_b};
            chk("strobe_edge", 32'(edge_n), 32'(mev.edge_n));
            chk("strobes", 32'(got_s), 32'(want_s));
         end
      end
   end

   // ---------------- stimulus ----------------
   int pr_a [NB], rl_a [NB], rp_a [NB], pr_b [NB];
   int both02;

   task automatic clr();
      for (int i = 0; i < NB; i++) begin
         pr_a[i] = 0; rl_a[i] = 0; rp_a[i] = 0; pr_b[i] = 0;
      end
      both02 = 0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         for (int i = 0; i < NB; i++) begin
            pr_a[i] += int'(o_press_a[i]);
            rl_a[i] += int'(o_release_a[i]);
            rp_a[i] += int'(o_repeat_a[i]);
            pr_b[i] += int'(o_press_b[i]);
         end
         if (o_press_a[0] && o_press_a[2]) both02++;
      end
   endtask

   task automatic chk_zero(input string name);
      chk(name, {o_level_a, o_press_a, o_release_a, o_repeat_a, o_level_b, o_press_b, o_release_b, o_repeat_b},
          32'd0);
      chk({name, "_tick"}, 32'({o_tick_a, o_tick_b}), 32'd0);
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1 chk_zero("reset_async");
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   logic [NB-1:0] m;
   int            left;

   initial begin
      rst = 1'b1;
      i_btn = '0;
      clr();
      repeat (3) @(negedge clk);
      #1 chk_zero("reset_init");
      #1 rst = 1'b0;
      run(30);

      // reset mid-count with all buttons held
      i_btn = 4'hF;
      run(31);
      pulse_reset();
      clr();
      run(14);
      chk("reset_repress_ch0", 32'(pr_a[0]), 32'd1);
      run(20);
      chk("alow_idle_no_press", 32'(pr_b[0] + pr_b[1] + pr_b[2] + pr_b[3]), 32'd0);
      i_btn = 4'h7;
      clr();
      run(20);
      chk("alow_press_ch3", 32'(pr_b[3]), 32'd1);
      chk("alow_release_a3", 32'(rl_a[3]), 32'd1);

      // bounce on ch0
      i_btn = '0;
      pulse_reset();
      clr();
      for (int k = 0; k < 40; k++) begin
         i_btn[0] = ~i_btn[0];
         run(1);
      end
      i_btn[0] = 1'b1;
      run(30);
      chk("bounce_press", 32'(pr_a[0]), 32'd1);
      chk("bounce_release", 32'(rl_a[0]), 32'd0);
      chk("bounce_level", 32'(o_level_a[0]), 32'd1);

      // short glitch on ch1
      clr();
      i_btn[1] = 1'b1;
      run(8);
      i_btn[1] = 1'b0;
      run(20);
      chk("glitch_press", 32'(pr_a[1]), 32'd0);
      chk("glitch_level", 32'(o_level_a[1]), 32'd0);

      // simultaneous press on ch0/ch2, release ch2 only
      i_btn = '0;
      run(30);
      clr();
      i_btn = 4'b0101;
      run(30);
      i_btn = 4'b0001;
      run(30);
      chk("indep_joint_press", 32'(both02), 32'd1);
      chk("indep_release_ch2", 32'(rl_a[2]), 32'd1);
      chk("indep_release_ch0", 32'(rl_a[0]), 32'd0);
      chk("indep_level_ch0", 32'(o_level_a[0]), 32'd1);

      // long hold for auto-repeat
      i_btn = '0;
      run(30);
      clr();
      i_btn = 4'b0001;
      run(100);
`ifdef DEBOUNCE_AUTOREPEAT_EN
      chk("repeat_seen", 32'(rp_a[0] >= 5), 32'd1);
`else
      chk("repeat_off", 32'(rp_a[0]), 32'd0);
`endif
      i_btn = '0;
      run(40);

      // randomized run with one reset in the middle
      left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) pulse_reset();
         if (left == 0) begin
            m = NB'($urandom_range(0, (1 << NB) - 1));
            i_btn = i_btn ^ m;
            left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(8, 80));
         end else begin
            left--;
         end
         run(1);
      end

      run(20);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner replacing the single-button debouncer. It synchronises N raw button inputs and debounces each with a per-channel integrating counter, all sharing one sample-tick divider. Each channel produces a clean level plus one-cycle press and release strobes, with optional auto-repeat. It sits between board pins and the matrix control logic; one instance serves every front-panel button.

## Interface
- `N_BTN`, 4: number of button channels (≥1).
- `TICK_DIV`, 250000: clk cycles per sample tick (≥2); 2.5 ms at 100 MHz.
- `STABLE_TICKS`, 4: consecutive agreeing samples required to change level (≥1).
- `ACTIVE_LOW`, 0: 1 means raw inputs are pressed-low; inverted before the synchroniser output.
- `REPEAT_DELAY`, 200: ticks held before the first repeat strobe (≥1; used only with auto-repeat).
- `REPEAT_RATE`, 40: ticks between subsequent repeat strobes (≥1; used only with auto-repeat).

- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `i_btn` in N_BTN: raw asynchronous button pins.
- `o_level` out N_BTN: debounced pressed state (1 = pressed).
- `o_press` out N_BTN: one-cycle strobe on debounced 0→1.
- `o_release` out N_BTN: one-cycle strobe on debounced 1→0.
- `o_repeat` out N_BTN: one-cycle auto-repeat strobe; constant 0 when the feature is compiled out.
- `o_tick` out 1: one-cycle sample-tick strobe, exported for other slow logic.

## Operation
- Divider: counter width `$clog2(TICK_DIV)`, counts 0..TICK_DIV-1 and wraps. `o_tick`=1 in the cycle where the count equals TICK_DIV-1.
- Synchroniser: 2-FF chain per channel, clocked every clk. Polarity is applied at the input, so `s[i]` = 1 means pressed. Both flops reset to 0.
- Integrator per channel: counter width `$clog2(STABLE_TICKS+1)`. Updates only on tick cycles:
  - `s[i]==o_level[i]`: counter ← 0.
  - `s[i]!=o_level[i]` and counter==STABLE_TICKS-1: `o_level[i]` ← `s[i]`, counter ← 0, fire the matching strobe.
  - Otherwise: counter ← counter+1.
- Strobes are registered and assert in the same cycle `o_level` changes, for exactly one clk. Press and release never occur together on one channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- Reset (async, any time, including mid-count): every counter, synchroniser flop, level and strobe goes to 0. A button held through reset deassertion re-qualifies as a new press after STABLE_TICKS ticks.

## Timing
- Reset values: `o_level`, `o_press`, `o_release`, `o_repeat`, `o_tick` all 0.
- Latency from a clean input edge to the level change is 2 clk (sync) plus the wait to the STABLE_TICKS-th agreeing tick. Worst case 2 + STABLE_TICKS·TICK_DIV clk; best case 2 + (STABLE_TICKS-1)·TICK_DIV + 1.
- A glitch lasting fewer than STABLE_TICKS consecutive tick samples never changes `o_level`.
- First tick after reset occurs at clk cycle TICK_DIV-1 after deassertion.

## Configuration
- `DEBOUNCE_AUTOREPEAT_EN` defined: each channel gets a hold counter, cleared whenever `o_level[i]`=0 and on press.
  - While the level is held, the counter increments per tick.
  - `o_repeat[i]` fires on the tick where held ticks reach REPEAT_DELAY, then every REPEAT_RATE ticks thereafter.
  - A release cancels repeating immediately, with no repeat strobe in the release cycle.
- Macro not defined: no hold counters are instantiated and `o_repeat` is tied to 0.

## Test plan
- Reset: assert `rst` mid-count with `i_btn`=all 1 → all outputs 0 immediately. After release, with TICK_DIV=4 and STABLE_TICKS=3, `o_press` fires once within 2+12 clk.
- Bounce: TICK_DIV=4, STABLE_TICKS=3. Toggle `i_btn[0]` every clk for 40 clk, then hold 1 → exactly one `o_press[0]`, no `o_release[0]`, `o_level[0]`=1 stays set.
- Short glitch: with level 0, pulse `i_btn[1]`=1 for 8 clk (2 ticks) → no strobe, `o_level[1]` stays 0.
- Release and independence: press ch0 and ch2 in the same cycle, then release ch2 only → simultaneous `o_press[0]`/`o_press[2]`, later a single `o_release[2]`, and ch0 unchanged.
- ACTIVE_LOW=1: drive `i_btn`=all 1 after reset → no strobes. Drive bit 3 low → `o_press[3]`.
- Auto-repeat (macro defined), REPEAT_DELAY=5, REPEAT_RATE=2: hold ch0 → `o_repeat[0]` 5 ticks after the press, then every 2 ticks. Release → no further repeats. Macro undefined → `o_repeat`=0 throughout.
